// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master front-end logic.
package spi_pkg;

  // Word width of the fsm_spi master; clients default to this size.
  localparam int SPI_DATA_W = 12;

  // Arbiter sequencing: grant, wait for the master to start, transfer, report.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LOW = 2'd1,
    XFER     = 2'd2,
    DONE     = 2'd3
  } arb_state_t;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin selector: returns the first set request bit
// found scanning upward from last+1, wrapping modulo NUM_REQ.
module spi_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  // Scan from farthest to nearest so the nearest set bit after 'last' wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last) + i) % NUM_REQ);
      if (req[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin front end that shares one fsm_spi master between several
// clients: grants one requester, latches its word, kicks the master and
// watches chip-select to report completion (or a start timeout).
module spi_tx_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = SPI_DATA_W,
  parameter int START_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic                      spi_tx_enable,
  output logic [DATA_W-1:0]         spi_data,
  input  logic                      spi_cs
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] winner_q;
  logic [IDX_W-1:0] pick_winner;
  logic             pick_valid;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_flag;
  logic             start_timeout;
  logic [DATA_W-1:0] req_words [NUM_REQ];

  // Present the flat request-data bus as one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_words[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  spi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .last   (last),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // The master failed to pull chip-select low within the allowed window.
  assign start_timeout = (wait_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and decoded outputs; chip-select low beats timeout.
  always_comb begin
    state_next    = state;
    spi_tx_enable = 1'b0;
    done          = '0;
    err           = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        spi_tx_enable = 1'b1;
        if (!spi_cs) begin
          state_next = XFER;
        end else if (start_timeout) begin
          state_next = DONE;
        end
      end
      XFER: begin
        if (spi_cs) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = gnt;
        err        = err_flag;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Grant, data latch, round-robin pointer, timeout counter and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      spi_data <= '0;
      winner_q <= '0;
      last     <= IDX_W'(NUM_REQ - 1);
      wait_cnt <= '0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt      <= ONE_HOT_0 << pick_winner;
            spi_data <= req_words[pick_winner];
            winner_q <= pick_winner;
            wait_cnt <= '0;
            err_flag <= 1'b0;
          end
        end
        WAIT_LOW: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (spi_cs && start_timeout) begin
            err_flag <= 1'b1;
          end
        end
        XFER: begin
        end
        DONE: begin
          last     <= winner_q;
          gnt      <= '0;
          err_flag <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter: directed scenarios followed by
// randomized transfers, predicted by a transaction-level reference model.
module tb_spi_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 12;
  localparam int TO = 64;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    done;
  logic             err;
  logic             spi_tx_enable;
  logic [DW-1:0]    spi_data;
  logic             spi_cs;

  int nCompared;
  int nMismatch;
  int modelLast;
  logic [DW-1:0] words [NR];

  spi_tx_arbiter #(
    .NUM_REQ       (NR),
    .DATA_W        (DW),
    .START_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .done          (done),
    .err           (err),
    .spi_tx_enable (spi_tx_enable),
    .spi_data      (spi_data),
    .spi_cs        (spi_cs)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requesting index scanning upward from last+1.
  function automatic int modelPick(input logic [NR-1:0] r);
    for (int j = 1; j <= NR; j++) begin
      int idx;
      idx = (modelLast + j) % NR;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic randomizeWords();
    for (int i = 0; i < NR; i++) words[i] = DW'($urandom);
  endtask

  // One full transfer: grant, k cycles before the master starts, xlen
  // cycles of transfer, completion. Options model a stuck master,
  // a withdrawn request, changing client data, or a reset mid-transfer.
  task automatic applyStimulus(input logic [NR-1:0] reqv, input int k, input int xlen,
                               input bit stuck, input bit withdraw, input bit mutate,
                               input bit abortRst);
    int w;
    logic [NR-1:0] oh;
    logic [DW-1:0] word;
    req      = reqv;
    req_data = {words[3], words[2], words[1], words[0]};
    w        = modelPick(reqv);
    oh       = NR'(1) << w;
    word     = words[w];
    tick();
    checkOutput("grant_gnt", 32'(gnt), 32'(oh));
    checkOutput("grant_en", 32'(spi_tx_enable), 32'd1);
    checkOutput("grant_data", 32'(spi_data), 32'(word));
    checkOutput("grant_done", 32'(done), 32'd0);
    if (stuck) begin
      spi_cs = 1'b1;
      for (int c = 2; c <= TO; c++) begin
        tick();
        checkOutput("timeout_en_high", 32'(spi_tx_enable), 32'd1);
        checkOutput("timeout_no_done", 32'(done), 32'd0);
      end
      tick();
      checkOutput("timeout_done", 32'(done), 32'(oh));
      checkOutput("timeout_err", 32'(err), 32'd1);
      checkOutput("timeout_en_low", 32'(spi_tx_enable), 32'd0);
    end else begin
      for (int c = 0; c < k; c++) begin
        tick();
        checkOutput("wait_en", 32'(spi_tx_enable), 32'd1);
        checkOutput("wait_gnt", 32'(gnt), 32'(oh));
      end
      spi_cs = 1'b0;
      tick();
      checkOutput("start_en_low", 32'(spi_tx_enable), 32'd0);
      checkOutput("start_gnt", 32'(gnt), 32'(oh));
      for (int c = 0; c < xlen; c++) begin
        if (c == 0 && withdraw) req = reqv & ~oh;
        if (c == 0 && mutate) req_data = ~req_data;
        if (c == 1 && abortRst) begin
          #2;
          rst_n = 1'b0;
          #1;
          checkOutput("rst_gnt", 32'(gnt), 32'd0);
          checkOutput("rst_en", 32'(spi_tx_enable), 32'd0);
          checkOutput("rst_done", 32'(done), 32'd0);
          checkOutput("rst_data", 32'(spi_data), 32'd0);
          spi_cs = 1'b1;
          req    = '0;
          tick();
          tick();
          rst_n = 1'b1;
          modelLast = NR - 1;
          return;
        end
        tick();
        checkOutput("xfer_done", 32'(done), 32'd0);
        checkOutput("xfer_gnt", 32'(gnt), 32'(oh));
        checkOutput("xfer_data", 32'(spi_data), 32'(word));
      end
      spi_cs = 1'b1;
      tick();
      checkOutput("done_pulse", 32'(done), 32'(oh));
      checkOutput("done_err", 32'(err), 32'd0);
    end
    modelLast = w;
    tick();
    checkOutput("after_done", 32'(done), 32'd0);
    checkOutput("after_gnt", 32'(gnt), 32'd0);
    checkOutput("after_en", 32'(spi_tx_enable), 32'd0);
    checkOutput("after_err", 32'(err), 32'd0);
  endtask

  // Directed scenarios, then randomized traffic, then the summary.
  initial begin
    nCompared = 0;
    nMismatch = 0;
    modelLast = NR - 1;
    rst_n     = 1'b0;
    spi_cs    = 1'b1;
    req       = '0;
    req_data  = '0;
    #3;
    checkOutput("reset_gnt", 32'(gnt), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_en", 32'(spi_tx_enable), 32'd0);
    checkOutput("reset_data", 32'(spi_data), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("idle_en", 32'(spi_tx_enable), 32'd0);

    $display("[TB] fairness: all requesters held");
    for (int n = 0; n < 5; n++) begin
      randomizeWords();
      applyStimulus(4'b1111, n % 3, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] single requester");
    req = '0;
    tick();
    randomizeWords();
    words[1] = 12'hA5C;
    applyStimulus(4'b0010, 2, 4, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] start timeout");
    randomizeWords();
    applyStimulus(4'b0001, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    randomizeWords();
    applyStimulus(4'b0001, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] request withdrawn");
    randomizeWords();
    applyStimulus(4'b0100, 1, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("withdrawn_no_gnt", 32'(gnt), 32'd0);
      checkOutput("withdrawn_no_en", 32'(spi_tx_enable), 32'd0);
    end

    $display("[TB] data isolation");
    randomizeWords();
    applyStimulus(4'b1000, 0, 4, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] async reset mid-transfer");
    randomizeWords();
    applyStimulus(4'b0010, 1, 4, 1'b0, 1'b0, 1'b0, 1'b1);
    randomizeWords();
    applyStimulus(4'b1001, 1, 2, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] randomized transfers");
    for (int n = 0; n < 30; n++) begin
      randomizeWords();
      applyStimulus(NR'($urandom_range(1, 15)), $urandom_range(0, 4), $urandom_range(1, 5),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 1) == 1), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
